nanocache_mem_arbiter: RTL and testbench

Shares a single main-memory line port between the instruction-cache and data-cache update engines of the NanoCache subsystem. Each side issues line-sized (8×32b) read refills, and the data side also issues write-backs. The block arbitrates between the two, registers the winning request onto the memory port and steers grant and read-data back to the owner. It sits between the cache top level and the SRAM/memory controller and holds at most one transaction in flight.

---
 rtl/nanocache_pkg.sv | 23 ++
 rtl/nanocache_arb_pick.sv | 31 +++
 rtl/nanocache_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_nanocache_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanocache_pkg.sv
// Shared types and constants for the NanoCache memory-port arbiter.
package nanocache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int LINE_BITS  = LINE_WORDS * 32;
    localparam int STRB_BITS  = LINE_WORDS * 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        GAP     = 2'd3
    } arb_state_e;

    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } arb_owner_e;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [STRB_BITS-1:0] strb_t;

endpackage

// File: rtl/nanocache_arb_pick.sv
// Combinational 2-way picker. NANOCACHE_ARB_RR_EN selects round-robin on ties;
// otherwise data has fixed priority over instr.
module nanocache_arb_pick
    import nanocache_pkg::*;
(
    input  logic       i_req_instr,
    input  logic       i_req_data,
`ifdef NANOCACHE_ARB_RR_EN
    input  arb_owner_e i_last,
`endif
    output logic [1:0] o_gnt
);

    always_comb begin
        // NOTE: assign every combinational output a default first so no path infers a latch.
        o_gnt = 2'b00;
        if (i_req_instr && i_req_data) begin
`ifdef NANOCACHE_ARB_RR_EN
            // On a tie the side that lost last time goes next.
            o_gnt = (i_last == DATA) ? 2'b01 : 2'b10;
`else
            o_gnt = 2'b10;
`endif
        end else if (i_req_data) begin
            o_gnt = 2'b10;
        end else if (i_req_instr) begin
            o_gnt = 2'b01;
        end
    end

endmodule

// File: rtl/nanocache_mem_arbiter.sv
// Shares one main-memory line port between the instr and data cache engines,
// one transaction in flight. NANOCACHE_ARB_RR_EN enables round-robin arbitration.
module nanocache_mem_arbiter
    import nanocache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_instr_rden,
    input  logic [ADDR_WIDTH-1:0]     i_instr_addr,
    output logic                      o_instr_gnt,
    output logic [LINE_WORDS*32-1:0]  o_instr_rdata,
    output logic                      o_instr_rvalid,
    input  logic                      i_data_rden,
    input  logic                      i_data_wren,
    input  logic [ADDR_WIDTH-1:0]     i_data_addr,
    input  logic [LINE_WORDS*32-1:0]  i_data_wdata,
    input  logic [LINE_WORDS*4-1:0]   i_data_wstrb,
    output logic                      o_data_gnt,
    output logic [LINE_WORDS*32-1:0]  o_data_rdata,
    output logic                      o_data_rvalid,
    output logic                      o_mem_rden,
    output logic                      o_mem_wren,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [LINE_WORDS*32-1:0]  o_mem_wdata,
    output logic [LINE_WORDS*4-1:0]   o_mem_wstrb,
    input  logic                      i_mem_gnt,
    input  logic [LINE_WORDS*32-1:0]  i_mem_rdata,
    input  logic                      i_mem_rvalid
);

    arb_state_e                 state_q, state_d;
    arb_owner_e                 owner_q, owner_d;
    logic                       mem_rden_q, mem_rden_d;
    logic                       mem_wren_q, mem_wren_d;
    logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
    logic [LINE_WORDS*32-1:0]   mem_wdata_q, mem_wdata_d;
    logic [LINE_WORDS*4-1:0]    mem_wstrb_q, mem_wstrb_d;
    logic [1:0]                 pick_gnt;
    logic                       rd_live;

`ifdef NANOCACHE_ARB_RR_EN
    arb_owner_e last_q, last_d;
`endif

    nanocache_arb_pick u_pick (
        .i_req_instr (i_instr_rden),
        .i_req_data  (i_data_rden | i_data_wren),
`ifdef NANOCACHE_ARB_RR_EN
        .i_last      (last_q),
`endif
        .o_gnt       (pick_gnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_rden_d  = mem_rden_q;
        mem_wren_d  = mem_wren_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
`ifdef NANOCACHE_ARB_RR_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_gnt[1]) begin
                    // A pending write-back goes before the data side's refill.
                    owner_d     = DATA;
                    mem_wren_d  = i_data_wren;
                    mem_rden_d  = ~i_data_wren;
                    mem_addr_d  = i_data_addr;
                    mem_wdata_d = i_data_wren ? i_data_wdata : '0;
                    mem_wstrb_d = i_data_wren ? i_data_wstrb : '0;
                    state_d     = ISSUE;
                end else if (pick_gnt[0]) begin
                    owner_d     = INSTR;
                    mem_wren_d  = 1'b0;
                    mem_rden_d  = 1'b1;
                    mem_addr_d  = i_instr_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    state_d     = ISSUE;
                end
`ifdef NANOCACHE_ARB_RR_EN
                if (pick_gnt != 2'b00) last_d = pick_gnt[1] ? DATA : INSTR;
`endif
            end
            ISSUE: begin
                if (i_mem_gnt) begin
                    mem_rden_d = 1'b0;
                    mem_wren_d = 1'b0;
                    state_d    = (mem_wren_q || i_mem_rvalid) ? GAP : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (i_mem_rvalid) state_d = IDLE;
            end
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
        if (i_rst) begin
            state_q     <= IDLE;
            owner_q     <= INSTR;
            mem_rden_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
`ifdef NANOCACHE_ARB_RR_EN
            last_q      <= INSTR;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_rden_q  <= mem_rden_d;
            mem_wren_q  <= mem_wren_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
`ifdef NANOCACHE_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    // A read is live while waiting for data, or when data arrives with the grant.
    assign rd_live = ~i_rst && ((state_q == WAIT_RD) ||
                                (state_q == ISSUE && i_mem_gnt && mem_rden_q));

    assign o_instr_gnt    = ~i_rst && (state_q == ISSUE) && (owner_q == INSTR) && i_mem_gnt;
    assign o_data_gnt     = ~i_rst && (state_q == ISSUE) && (owner_q == DATA) && i_mem_gnt;
    assign o_instr_rvalid = rd_live && (owner_q == INSTR) && i_mem_rvalid;
    assign o_data_rvalid  = rd_live && (owner_q == DATA) && i_mem_rvalid;
    assign o_instr_rdata  = i_mem_rdata;
    assign o_data_rdata   = i_mem_rdata;

    assign o_mem_rden  = mem_rden_q;
    assign o_mem_wren  = mem_wren_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_nanocache_mem_arbiter.sv
// Directed scoreboard bench for nanocache_mem_arbiter; expected transactions are
// queued when requests are raised and compared as the memory port issues them.
module tb_nanocache_mem_arbiter;
    import nanocache_pkg::*;

    typedef struct packed {
        logic        is_data;
        logic        is_write;
        logic [31:0] addr;
        line_t       wdata;
        strb_t       wstrb;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_instr_rden;
    logic [31:0] i_instr_addr;
    logic        o_instr_gnt;
    line_t       o_instr_rdata;
    logic        o_instr_rvalid;
    logic        i_data_rden;
    logic        i_data_wren;
    logic [31:0] i_data_addr;
    line_t       i_data_wdata;
    strb_t       i_data_wstrb;
    logic        o_data_gnt;
    line_t       o_data_rdata;
    logic        o_data_rvalid;
    logic        o_mem_rden;
    logic        o_mem_wren;
    logic [31:0] o_mem_addr;
    line_t       o_mem_wdata;
    strb_t       o_mem_wstrb;
    logic        i_mem_gnt;
    line_t       i_mem_rdata;
    logic        i_mem_rvalid;

    exp_t sb_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
`ifdef NANOCACHE_ARB_RR_EN
    arb_owner_e tb_last = INSTR;
`endif

    always #5 clk = ~clk;

    nanocache_mem_arbiter dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_instr_rden   (i_instr_rden),
        .i_instr_addr   (i_instr_addr),
        .o_instr_gnt    (o_instr_gnt),
        .o_instr_rdata  (o_instr_rdata),
        .o_instr_rvalid (o_instr_rvalid),
        .i_data_rden    (i_data_rden),
        .i_data_wren    (i_data_wren),
        .i_data_addr    (i_data_addr),
        .i_data_wdata   (i_data_wdata),
        .i_data_wstrb   (i_data_wstrb),
        .o_data_gnt     (o_data_gnt),
        .o_data_rdata   (o_data_rdata),
        .o_data_rvalid  (o_data_rvalid),
        .o_mem_rden     (o_mem_rden),
        .o_mem_wren     (o_mem_wren),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_wstrb    (o_mem_wstrb),
        .i_mem_gnt      (i_mem_gnt),
        .i_mem_rdata    (i_mem_rdata),
        .i_mem_rvalid   (i_mem_rvalid)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed no memory request expected one within 20 cycles", tag);
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Reference arbitration: which side should win given the current requests.
    task automatic predict(input bit ri, input bit rd, output bit win_data);
`ifdef NANOCACHE_ARB_RR_EN
        if (ri && rd) win_data = (tb_last == INSTR);
        else          win_data = rd;
        tb_last = win_data ? DATA : INSTR;
`else
        win_data = rd;
        if (!ri && !rd) win_data = 1'b0;
`endif
    endtask

    task automatic push(input bit is_data, input bit is_write, input logic [31:0] addr,
                        input line_t wdata, input strb_t wstrb);
        exp_t e;
        e.is_data  = is_data;
        e.is_write = is_write;
        e.addr     = addr;
        e.wdata    = is_write ? wdata : '0;
        e.wstrb    = is_write ? wstrb : '0;
        sb_q.push_back(e);
    endtask

    // Acts as the memory for one transaction and checks it against the scoreboard head.
    task automatic serve(input int gnt_dly, input int rv_dly, input line_t rpat,
                         input bit rv_with_gnt, input bit keep);
        exp_t        e;
        int          n;
        logic [31:0] a;
        logic [1:0]  own;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_empty: observed 0 queued expected at least 1");
            return;
        end
        e   = sb_q.pop_front();
        own = e.is_data ? 2'b10 : 2'b01;
        n   = 0;
        while (!(o_mem_rden || o_mem_wren) && n < 20) begin
            cyc();
            n++;
        end
        if (n == 20) begin
            fail_timeout("mem_req_wait");
            return;
        end
        check("mem_wren", o_mem_wren, e.is_write);
        check("mem_rden", o_mem_rden, !e.is_write);
        check("mem_addr", o_mem_addr, e.addr);
        if (e.is_write) begin
            check("mem_wdata", o_mem_wdata, e.wdata);
            check("mem_wstrb", o_mem_wstrb, e.wstrb);
        end
        a = o_mem_addr;
        repeat (gnt_dly) begin
            i_mem_gnt = 1'b0;
            #1;
            check("gnt_held_low", {o_data_gnt, o_instr_gnt}, 2'b00);
            cyc();
            check("addr_stable", o_mem_addr, a);
            check("req_held", {o_mem_wren, o_mem_rden}, {e.is_write, !e.is_write});
        end
        i_mem_gnt = 1'b1;
        if (rv_with_gnt) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rpat;
        end
        #1;
        check("owner_gnt", {o_data_gnt, o_instr_gnt}, own);
        if (rv_with_gnt) begin
            check("rvalid_with_gnt", {o_data_rvalid, o_instr_rvalid}, own);
            check("rdata_with_gnt", e.is_data ? o_data_rdata : o_instr_rdata, rpat);
        end
        cyc();
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        if (!keep) begin
            if (!e.is_data)     i_instr_rden = 1'b0;
            else if (e.is_write) i_data_wren = 1'b0;
            else                i_data_rden  = 1'b0;
        end
        check("mem_req_cleared", {o_mem_rden, o_mem_wren}, 2'b00);
        if (e.is_write || rv_with_gnt) begin
            i_mem_rvalid = 1'b1;
            #1;
            check("gap_rvalid_dropped", {o_data_rvalid, o_instr_rvalid}, 2'b00);
            i_mem_rvalid = 1'b0;
        end else begin
            repeat (rv_dly) begin
                check("rvalid_wait_low", {o_data_rvalid, o_instr_rvalid}, 2'b00);
                cyc();
            end
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rpat;
            #1;
            check("owner_rvalid", {o_data_rvalid, o_instr_rvalid}, own);
            check("instr_rdata", o_instr_rdata, rpat);
            check("data_rdata", o_data_rdata, rpat);
            cyc();
            i_mem_rvalid = 1'b0;
            #1;
            check("rvalid_pulse_end", {o_data_rvalid, o_instr_rvalid}, 2'b00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit    w;
        line_t pat;
        line_t wd;
        i_rst = 1'b1;
        i_instr_rden = 1'b0; i_instr_addr = '0;
        i_data_rden = 1'b0;  i_data_wren = 1'b0; i_data_addr = '0;
        i_data_wdata = '0;   i_data_wstrb = '0;
        i_mem_gnt = 1'b0;    i_mem_rdata = '0;   i_mem_rvalid = 1'b0;
        cyc();
        cyc();
        check("reset_mem_outputs", {o_mem_rden, o_mem_wren, o_mem_addr, o_mem_wstrb}, '0);
        check("reset_mem_wdata", o_mem_wdata, '0);
        check("reset_gnt_rvalid", {o_instr_gnt, o_data_gnt, o_instr_rvalid, o_data_rvalid}, 4'h0);
        i_rst = 1'b0;
        cyc();

        // Instr refill at 0x100: gnt one cycle after issue, data one cycle after that.
        i_instr_addr = 32'h100;
        i_instr_rden = 1'b1;
        predict(1'b1, 1'b0, w);
        push(w, 1'b0, 32'h100, '0, '0);
        #1;
        check("issue_latency_c0", o_mem_rden, 1'b0);
        pat = {32{8'hA5}};
        serve(1, 1, pat, 1'b0, 1'b0);

        // Data write-back at 0x2000, full strobes, immediate grant.
        cyc();
        i_data_addr  = 32'h2000;
        i_data_wdata = {8{32'h1234_5678}};
        i_data_wstrb = '1;
        i_data_wren  = 1'b1;
        predict(1'b0, 1'b1, w);
        push(w, 1'b1, 32'h2000, i_data_wdata, i_data_wstrb);
        serve(0, 0, '0, 1'b0, 1'b0);
        cyc();

        // Both sides hold refill requests through four arbitration rounds.
        i_instr_addr = 32'h1400;
        i_data_addr  = 32'h3400;
        i_instr_rden = 1'b1;
        i_data_rden  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            predict(1'b1, 1'b1, w);
            push(w, 1'b0, w ? 32'h3400 : 32'h1400, '0, '0);
            pat = {8{k[7:0] + 8'h10, 8'h5A, 8'hC3, 8'h0F}};
            serve(k % 2, 0, pat, (k == 2), 1'b1);
        end
        i_data_rden = 1'b0;
        predict(1'b1, 1'b0, w);
        push(w, 1'b0, 32'h1400, '0, '0);
        serve(0, 0, {8{32'hFEED_0001}}, 1'b0, 1'b0);
        cyc();
        cyc();

        // Write-back and refill raised together: write first, read after the gap.
        i_data_addr  = 32'h3000;
        wd           = {8{32'hCAFE_F00D}};
        i_data_wdata = wd;
        i_data_wstrb = {8{4'h3}};
        i_data_wren  = 1'b1;
        i_data_rden  = 1'b1;
        predict(1'b0, 1'b1, w);
        push(w, 1'b1, 32'h3000, wd, {8{4'h3}});
        predict(1'b0, 1'b1, w);
        push(w, 1'b0, 32'h3000, '0, '0);
        serve(0, 0, '0, 1'b0, 1'b0);
        cyc();
        check("idle_after_gap", o_mem_rden, 1'b0);
        cyc();
        check("read_after_gap", o_mem_rden, 1'b1);
        serve(0, 0, {8{32'h0BAD_BEEF}}, 1'b0, 1'b0);
        cyc();
        cyc();

        // Reset in WAIT_RD abandons the refill; a late rvalid must be dropped.
        i_instr_addr = 32'h400;
        i_instr_rden = 1'b1;
        cyc();
        check("rst_case_issue", o_mem_rden, 1'b1);
        i_mem_gnt = 1'b1;
        #1;
        check("rst_case_gnt", o_instr_gnt, 1'b1);
        cyc();
        i_mem_gnt    = 1'b0;
        i_instr_rden = 1'b0;
        i_rst        = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = {8{32'h7777_7777}};
        #1;
        check("rvalid_during_rst", {o_data_rvalid, o_instr_rvalid}, 2'b00);
        cyc();
        i_rst = 1'b0;
`ifdef NANOCACHE_ARB_RR_EN
        tb_last = INSTR;
`endif
        #1;
        check("late_rvalid_dropped", {o_data_rvalid, o_instr_rvalid}, 2'b00);
        check("rst_mem_outputs", {o_mem_rden, o_mem_wren, o_mem_addr, o_mem_wstrb}, '0);
        cyc();
        i_mem_rvalid = 1'b0;
        i_instr_addr = 32'h500;
        i_instr_rden = 1'b1;
        predict(1'b1, 1'b0, w);
        push(w, 1'b0, 32'h500, '0, '0);
        serve(0, 2, {8{32'h5555_AAAA}}, 1'b0, 1'b0);
        cyc();
        cyc();

        // Spurious rvalid in IDLE, then a refill whose grant is held off for 5 cycles.
        i_mem_rvalid = 1'b1;
        #1;
        check("idle_rvalid_ignored", {o_data_rvalid, o_instr_rvalid}, 2'b00);
        cyc();
        i_mem_rvalid = 1'b0;
        check("idle_no_issue", {o_mem_rden, o_mem_wren}, 2'b00);
        i_data_addr = 32'h600;
        i_data_rden = 1'b1;
        predict(1'b0, 1'b1, w);
        push(w, 1'b0, 32'h600, '0, '0);
        serve(5, 0, {8{32'h6006_6006}}, 1'b0, 1'b0);
        cyc();

        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
